// File: rtl/cla_pkg.sv
// Shared elaboration-time helpers for the pipelined carry-lookahead adder.
//   calc_nstage : number of pipeline stages (ceil(groups / groups-per-stage))
//   cfg_legal   : width/group/stage-grouping legality check
package cla_pkg;

    function automatic int ceil_div(input int n, input int d);
        if (d < 1) return n;
        return (n + d - 1) / d;
    endfunction

    function automatic int calc_nstage(input int ng, input int pg);
        int r;
        r = ceil_div(ng, pg);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit cfg_legal(input int width, input int gw, input int pg);
        if (width < 1 || gw < 1 || pg < 1) return 1'b0;
        return (width % gw) == 0;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP_W-bit carry-lookahead group (purely combinational).
//   a, b  : operand slices
//   cin   : carry into the group's LSB
//   sum   : sum slice
//   cout  : carry out of the group's MSB
//   cmsb  : carry into the group's MSB (used for signed overflow)
module cla_group #(
    parameter int GROUP_W = 4
) (
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               cout,
    output logic               cmsb
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W:0]   c;

    // Carry into bit i as a flat sum of products:
    // cin & p[0..i-1]  |  OR over j<i of g[j] & p[j+1..i-1]
    function automatic logic carry_at(input int i, input logic [GROUP_W-1:0] gg,
                                      input logic [GROUP_W-1:0] pp, input logic ci);
        logic acc;
        logic term;
        acc = ci;
        for (int j = 0; j < i; j++) acc = acc & pp[j];
        for (int j = 0; j < i; j++) begin
            term = gg[j];
            for (int k = j + 1; k < i; k++) term = term & pp[k];
            acc = acc | term;
        end
        return acc;
    endfunction

    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        for (int i = 0; i <= GROUP_W; i++) c[i] = carry_at(i, g, p, cin);
    end

    assign sum  = p ^ c[GROUP_W-1:0];
    assign cout = c[GROUP_W];
    assign cmsb = c[GROUP_W-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each stage evaluates PIPE_GROUPS lookahead groups; the upper operand slices
// ride forward in skew registers and the finished lower sum slices ride
// forward in deskew registers, so a beat's whole result leaves the last stage
// together, NSTAGE cycles after it was accepted.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake
//   in_a, in_b           : operands
//   in_cin               : carry-in (add) or borrow-in (subtract)
//   in_sub               : 1 = A - B - in_cin, 0 = A + B + in_cin
//   out_valid / out_ready: result handshake
//   out_sum, out_cout    : result and raw MSB carry (subtract: 1 = no borrow)
//   out_ovf              : signed overflow
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// The pipeline stalls globally: when out_valid is 1 and out_ready is 0 every
// stage register holds, in_ready is 0 and the output stays stable.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int GROUP_W     = 4,
    parameter int PIPE_GROUPS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    if (!cfg_legal(WIDTH, GROUP_W, PIPE_GROUPS)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP_W and PIPE_GROUPS >= 1");
    end

    // Guarded copies keep the remaining elaboration arithmetic defined even
    // when the configuration is rejected above.
    localparam int GW     = (GROUP_W < 1) ? 1 : GROUP_W;
    localparam int PG     = (PIPE_GROUPS < 1) ? 1 : PIPE_GROUPS;
    localparam int NG     = (WIDTH / GW < 1) ? 1 : WIDTH / GW;
    localparam int NSTAGE = calc_nstage(NG, PG);

    function automatic int last_group(input int s);
        int l;
        l = (s + 1) * PG;
        if (l > NG) l = NG;
        return l - 1;
    endfunction

    // Bits of the result produced by stage s.
    function automatic logic [WIDTH-1:0] stage_mask(input int s);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) m[i] = ((i / GW) / PG) == s;
        return m;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Stage registers: valid, skewed operands, partial sum, carry out.
    logic             v_q   [NSTAGE];
    logic [WIDTH-1:0] a_q   [NSTAGE];
    logic [WIDTH-1:0] b_q   [NSTAGE];
    logic [WIDTH-1:0] sum_q [NSTAGE];
    logic             c_q   [NSTAGE];
    logic             ovf_q;

    // What each stage sees at its input (previous stage or the port).
    logic             v_in   [NSTAGE];
    logic [WIDTH-1:0] a_in   [NSTAGE];
    logic [WIDTH-1:0] b_in   [NSTAGE];
    logic [WIDTH-1:0] sum_in [NSTAGE];
    logic             c_in   [NSTAGE];
    logic [WIDTH-1:0] sum_d  [NSTAGE];
    logic [NSTAGE-1:0] st_cout;

    logic [WIDTH-1:0] gsum;
    logic [NG-1:0]    gcin;
    logic [NG-1:0]    gcout;
    logic [NG-1:0]    gcmsb;

    assign advance = !v_q[NSTAGE-1] | out_ready;
    assign in_ready = advance;

    // Subtract as A + ~B + ~borrow.
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? ~in_cin : in_cin;

    always_comb begin
        v_in[0]   = in_valid;
        a_in[0]   = in_a;
        b_in[0]   = b_eff;
        sum_in[0] = '0;
        c_in[0]   = cin_eff;
        for (int s = 1; s < NSTAGE; s++) begin
            v_in[s]   = v_q[s-1];
            a_in[s]   = a_q[s-1];
            b_in[s]   = b_q[s-1];
            sum_in[s] = sum_q[s-1];
            c_in[s]   = c_q[s-1];
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        // The first group of a stage takes the stage carry; the rest ripple.
        if ((g % PG) == 0) begin : g_first
            assign gcin[g] = c_in[g/PG];
        end else begin : g_chain
            assign gcin[g] = gcout[g-1];
        end

        cla_group #(.GROUP_W(GW)) u_grp (
            .a    (a_in[g/PG][g*GW +: GW]),
            .b    (b_in[g/PG][g*GW +: GW]),
            .cin  (gcin[g]),
            .sum  (gsum[g*GW +: GW]),
            .cout (gcout[g]),
            .cmsb (gcmsb[g])
        );
    end

    always_comb begin
        for (int s = 0; s < NSTAGE; s++) begin
            sum_d[s]   = (sum_in[s] & ~stage_mask(s)) | (gsum & stage_mask(s));
            st_cout[s] = gcout[last_group(s)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTAGE; s++) begin
                v_q[s]   <= 1'b0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
                c_q[s]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < NSTAGE; s++) begin
                v_q[s]   <= v_in[s];
                a_q[s]   <= a_in[s];
                b_q[s]   <= b_in[s];
                sum_q[s] <= sum_d[s];
                c_q[s]   <= st_cout[s];
            end
            // The MSB group always lives in the final stage.
            ovf_q <= gcmsb[NG-1] ^ gcout[NG-1];
        end
    end

    assign out_valid = v_q[NSTAGE-1];
    assign out_sum   = sum_q[NSTAGE-1];
    assign out_cout  = c_q[NSTAGE-1];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three instances (32/4/2, 8/4/1, 12/4/2) checked
// against a signed/unsigned arithmetic model through per-instance expected
// queues, plus directed vectors with literal expectations.
module tb_cla_pipe_adder;

    logic clk;
    logic rst_n;

    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic        isub [3];
    logic        icin [3];
    logic        oc   [3];
    logic        oo   [3];
    logic [31:0] ia   [3];
    logic [31:0] ib   [3];
    logic [31:0] os   [3];

    logic [31:0] s0;
    logic [7:0]  s1;
    logic [11:0] s2;

    int n_vec;
    int n_err;

    logic [33:0] exp_q [3][$];
    logic        held   [3];
    logic [33:0] held_v [3];

    localparam int WS   [3] = '{32, 8, 12};
    localparam int LATS [3] = '{4, 2, 2};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    cla_pipe_adder #(.WIDTH(32), .GROUP_W(4), .PIPE_GROUPS(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[0]), .in_b(ib[0]), .in_cin(icin[0]), .in_sub(isub[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0),
        .out_cout(oc[0]), .out_ovf(oo[0])
    );

    cla_pipe_adder #(.WIDTH(8), .GROUP_W(4), .PIPE_GROUPS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_cin(icin[1]), .in_sub(isub[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1),
        .out_cout(oc[1]), .out_ovf(oo[1])
    );

    cla_pipe_adder #(.WIDTH(12), .GROUP_W(4), .PIPE_GROUPS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(ia[2][11:0]), .in_b(ib[2][11:0]), .in_cin(icin[2]), .in_sub(isub[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2),
        .out_cout(oc[2]), .out_ovf(oo[2])
    );

    assign os[0] = s0;
    assign os[1] = {24'b0, s1};
    assign os[2] = {20'b0, s2};

    // ---------------- reference model ----------------
    // {ovf, cout, sum}: sum/cout from unsigned A + B' + c' (raw carry),
    // ovf from whether the exact signed result fits in w bits.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic cin, input int w);
        logic [63:0] msk;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] ue;
        longint      sa;
        longint      sb;
        longint      ex;
        logic        ovf;
        msk = (64'd1 << w) - 64'd1;
        ua  = {32'b0, a} & msk;
        ub  = {32'b0, b} & msk;
        if (sub) ue = ua + ((~ub) & msk) + {63'b0, ~cin};
        else     ue = ua + ub + {63'b0, cin};
        sa = longint'(ua);
        sb = longint'(ub);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        ex  = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
        ovf = (ex < -(longint'(1) << (w - 1))) || (ex >= (longint'(1) << (w - 1)));
        return {ovf, ue[w], ue[31:0] & msk[31:0]};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                exp_q[k].delete();
                held[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [33:0] act;
                logic [33:0] e;
                act = {oo[k], oc[k], os[k]};
                if (held[k]) begin
                    n_vec++;
                    if (!ov[k] || act !== held_v[k]) begin
                        n_err++;
                        $display("FAIL hold[%0d]: got v=%0b %h required v=1 %h", k, ov[k], act, held_v[k]);
                    end
                end
                held[k]   = ov[k] && !ordy[k];
                held_v[k] = act;
                if (ov[k] && ordy[k]) begin
                    n_vec++;
                    if (exp_q[k].size() == 0) begin
                        n_err++;
                        $display("FAIL spurious[%0d]: got result %h with nothing expected", k, act);
                    end else begin
                        e = exp_q[k].pop_front();
                        if (act !== e) begin
                            n_err++;
                            $display("FAIL result[%0d]: got ovf/cout/sum %h required %h", k, act, e);
                        end
                    end
                end
                if (iv[k] && ir[k])
                    exp_q[k].push_back(model(ia[k], ib[k], isub[k], icin[k], WS[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // One beat on an idle pipe; checks latency and literal results.
    task automatic send_one(input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic cin, input logic [31:0] e_sum,
                            input logic e_cout, input logic e_ovf, input string name);
        int cyc;
        @(posedge clk); #1;
        ia[k] = a; ib[k] = b; isub[k] = sub; icin[k] = cin; iv[k] = 1'b1;
        chk({name, "_in_ready"}, {63'b0, ir[k]}, 64'd1);
        @(posedge clk); #1;
        iv[k] = 1'b0;
        cyc = 1;
        while (!ov[k] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'(LATS[k]));
        chk({name, "_sum"},  {32'b0, os[k]}, {32'b0, e_sum});
        chk({name, "_cout"}, {63'b0, oc[k]}, {63'b0, e_cout});
        chk({name, "_ovf"},  {63'b0, oo[k]}, {63'b0, e_ovf});
    endtask

    // Present beats back-to-back, holding each until accepted.
    task automatic stream(input int k, input int n, input logic [31:0] a0, input logic [31:0] astep,
                          input logic [31:0] bmul);
        logic acc;
        int   t;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            ia[k] = a0 + astep * i; ib[k] = bmul * i; isub[k] = 1'b0; icin[k] = 1'b0;
            iv[k] = 1'b1;
            acc = 1'b0;
            t = 0;
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = ir[k];
                @(posedge clk); #1;
                t++;
            end
            if (!acc) chk("stream_accept_timeout", 64'd0, 64'd1);
        end
        iv[k] = 1'b0;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] msk);
        case ($urandom_range(0, 4))
            0:       return msk;
            1:       return 32'd0;
            2:       return (msk >> 1) + 32'd1;
            default: return $urandom() & msk;
        endcase
    endfunction

    task automatic rand_run(input int k, input int n);
        logic [31:0] msk;
        logic        acc;
        int          got;
        int          cyc;
        msk = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'h0000_00FF : 32'h0000_0FFF;
        got = 0;
        cyc = 0;
        @(posedge clk); #1;
        iv[k] = 1'b1; ia[k] = pick(msk); ib[k] = pick(msk);
        isub[k] = 1'($urandom_range(0, 1)); icin[k] = 1'($urandom_range(0, 1));
        while (got < n && cyc < n * 4) begin
            @(negedge clk);
            acc = iv[k] && ir[k];
            if (acc) got++;
            @(posedge clk); #1;
            cyc++;
            if (!iv[k] || acc) begin
                iv[k]   = ($urandom_range(0, 9) != 0);
                ia[k]   = pick(msk);
                ib[k]   = pick(msk);
                isub[k] = 1'($urandom_range(0, 1));
                icin[k] = 1'($urandom_range(0, 1));
            end
            ordy[k] = ($urandom_range(0, 4) != 0);
        end
        chk("rand_beats_accepted", 64'(got), 64'(n));
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t;
        n_vec = 0;
        n_err = 0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; ia[k] = '0; ib[k] = '0;
            isub[k] = 1'b0; icin[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'b0, ov[0]}, 64'd0);
        chk("reset_out_sum",   {32'b0, os[0]}, 64'd0);
        chk("reset_out_cout",  {63'b0, oc[0]}, 64'd0);
        chk("reset_out_ovf",   {63'b0, oo[0]}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {63'b0, ir[0]}, 64'd1);

        // Directed vectors, default configuration.
        send_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "carry_all");
        send_one(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        send_one(0, 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        send_one(0, 32'd7, 32'd5, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, "sub_pos");
        send_one(0, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        send_one(0, 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, "sub_borrow_in");
        send_one(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b1, "add_neg_ovf");

        // Other configurations.
        send_one(1, 32'hF0, 32'h10, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, "w8_carry");
        send_one(1, 32'h00, 32'h01, 1'b1, 1'b0, 32'hFF, 1'b0, 1'b0, "w8_sub_neg");
        send_one(2, 32'hFFF, 32'h001, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, "w12_carry");
        send_one(2, 32'h7FF, 32'h001, 1'b0, 1'b0, 32'h800, 1'b0, 1'b1, "w12_ovf");

        // Backpressure: 6 beats, out_ready low for 3 cycles from first out_valid.
        repeat (3) @(posedge clk);
        fork
            stream(0, 6, 32'd0, 32'd1, 32'h1000_0001);
            begin
                t = 0;
                @(posedge clk); #1;
                while (!ov[0] && t < 50) begin
                    @(posedge clk); #1;
                    t++;
                end
                chk("bp_first_valid_seen", {63'b0, ov[0]}, 64'd1);
                ordy[0] = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", {63'b0, ir[0]}, 64'd0);
                    @(posedge clk); #1;
                end
                ordy[0] = 1'b1;
                @(negedge clk);
                chk("bp_in_ready_back", {63'b0, ir[0]}, 64'd1);
            end
        join
        repeat (12) @(posedge clk);
        #1;
        chk("bp_all_delivered", 64'(exp_q[0].size()), 64'd0);

        // Reset mid-flight.
        ordy[0] = 1'b0;
        stream(0, 3, 32'h1111_1111, 32'h1111_1111, 32'h0101_0101);
        t = 0;
        while (!ov[0] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_pre_valid", {63'b0, ov[0]}, 64'd1);
        chk("rst_pre_sum",   {32'b0, os[0]}, 64'h1111_1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {63'b0, ov[0]}, 64'd0);
        chk("rst_async_sum",   {32'b0, os[0]}, 64'd0);
        chk("rst_async_cout",  {63'b0, oc[0]}, 64'd0);
        chk("rst_async_ovf",   {63'b0, oo[0]}, 64'd0);
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        #1;
        chk("rst_in_ready", {63'b0, ir[0]}, 64'd1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("rst_no_emit", {63'b0, ov[0]}, 64'd0);
        end

        // Random add/sub against the model, each configuration.
        rand_run(0, 10000);
        rand_run(1, 10000);
        rand_run(2, 10000);

        chk("final_q0_empty", 64'(exp_q[0].size()), 64'd0);
        chk("final_q1_empty", 64'(exp_q[1].size()), 64'd0);
        chk("final_q2_empty", 64'(exp_q[2].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from chained GROUP_W-bit lookahead groups.
- Pipeline registers sit every PIPE_GROUPS groups, so wide adds close timing at high clock rates.
- Valid/ready handshake on both sides; adds a subtract mode, a carry-out and a signed-overflow flag.
- Serves as the arithmetic core for the team's ALU datapaths at any width that is a multiple of GROUP_W.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of GROUP_W.
- GROUP_W, 4, bits per lookahead group.
- PIPE_GROUPS, 2, groups evaluated per pipeline stage, ≥1.
- Derived NG = WIDTH/GROUP_W.
- Derived NSTAGE = ceil(NG/PIPE_GROUPS), which is also the latency.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operand beat valid.
- in_ready, out, 1, pipeline accepts a beat.
- in_a, in, WIDTH, operand A.
- in_b, in, WIDTH, operand B.
- in_cin, in, 1, carry-in for add; borrow-in for subtract.
- in_sub, in, 1, 1 = A − B − in_cin, 0 = A + B + in_cin.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_sum, out, WIDTH, result bits.
- out_cout, out, 1, raw carry out of MSB; on subtract, 1 = no borrow.
- out_ovf, out, 1, signed overflow.

Behaviour:
- Operand conditioning at accept: b_eff = in_sub ? ~in_b : in_b; cin_eff = in_sub ? ~in_cin : in_cin.
- Stage s (0..NSTAGE-1) computes groups s·PIPE_GROUPS .. min((s+1)·PIPE_GROUPS, NG)−1.
  - Carry into stage s is the registered carry-out of stage s−1; stage 0 uses cin_eff.
  - Inside a stage, the groups ripple group-carry combinationally.
  - Each group is a full GROUP_W lookahead using g = a&b and p = a^b.
- Skew registers carry the not-yet-used upper operand slices forward.
- Deskew registers carry the already-computed lower sum slices forward.
- All slices of one beat emerge together in the final stage.
- Latency: the result is valid NSTAGE cycles after the accept edge (in_valid & in_ready). Throughput is 1 beat/cycle when unstalled.
- Flow control is a global stall:
  - advance = !out_valid | out_ready.
  - in_ready = advance.
  - When advance = 0, every stage register, including valid bits, holds.
  - Bubbles are not squeezed out.
- out_valid is held high with stable out_sum, out_cout and out_ovf until out_ready = 1.
- out_ovf = carry into MSB XOR carry out of MSB. Computed in the final stage and valid for both add and subtract.
- Reset (rst_n low, asynchronous):
  - All stage valid bits, out_valid, out_sum, out_cout and out_ovf clear to 0 immediately.
  - in_ready reads 1 once reset deasserts, since out_valid = 0.
  - In-flight beats are dropped and never emitted.
- in_valid low with in_ready high: a bubble enters; the data registers may load but their valid bit is 0.
- in_valid high during a stall: not accepted; the source must hold the beat.
- NSTAGE = 1 degenerates to a single-register adder with latency 1.
- Elaboration error if WIDTH % GROUP_W != 0 or PIPE_GROUPS = 0.

Decomposition:
- Shared package cla_pkg holds the elaboration-time function for NSTAGE (ceil division) and a check function for WIDTH/GROUP_W legality.
- One sub-module, cla_group: parametrised GROUP_W-bit combinational lookahead group.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and the MSB carry-in (needed for ovf).
  - Instantiated NG times via generate.
- The top level holds the stage/skew/deskew registers and handshake.

Test Plan:
- Carry through all groups (defaults; NSTAGE=4): a=0xFFFFFFFF, b=0x00000001, add, cin=0 → out_sum=0x00000000, cout=1, ovf=0; out_valid rises exactly 4 cycles after accept.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, add → sum=0x80000000, cout=0, ovf=1.
- Subtract:
  - a=5, b=7, sub, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=7, b=5 → sum=0x00000002, cout=1.
  - a=0x80000000, b=1, sub → sum=0x7FFFFFFF, ovf=1.
  - a=7, b=5, sub, in_cin=1 → sum=0x00000001.
- Backpressure: stream 6 back-to-back beats (a=i, b=i·0x10000001, add), out_ready low for 3 cycles starting at the first out_valid.
  - in_ready low during exactly those cycles.
  - Outputs held stable.
  - All 6 results arrive in order, none lost or duplicated.
- Reset mid-flight: accept 3 beats, then pulse rst_n low between clock edges → outputs clear without a clock edge; after release, nothing emerges for ≥NSTAGE cycles with in_valid=0.
- Parameter sweep:
  - WIDTH=8, GROUP_W=4, PIPE_GROUPS=1 → latency 2; 0xF0+0x10 → sum=0x00, cout=1.
  - WIDTH=12, GROUP_W=4, PIPE_GROUPS=2 → NSTAGE=2; 0xFFF+0x001 → 0x000, cout=1.
  - Random add/sub vs. reference model, 10k beats each configuration.
